// File: rtl/typing_game_sched.sv
// rtl/typing_game_sched.sv - slot pool scheduler and WELCOME/PLAY/OVER FSM for the falling-character typing game
module typing_game_sched #(
    parameter int NSLOTS      = 8,
    parameter int LOWER_BOUND = 480,
    parameter int SCORE_MAX   = 255,
    localparam int IW         = $clog2(NSLOTS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          spawn_valid,
    input  logic [7:0]    spawn_ascii,
    input  logic [9:0]    spawn_col,
    input  logic [8:0]    spawn_row,
    input  logic [2:0]    spawn_speed,
    output logic          spawn_ready,
    input  logic          tick,
    input  logic          key_valid,
    input  logic [7:0]    key_ascii,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_live,
    output logic [7:0]    rd_ascii,
    output logic [9:0]    rd_col,
    output logic [9:0]    rd_row,
    output logic [1:0]    state,
    output logic [7:0]    score,
    output logic          gameover,
    output logic          hit
);
    typedef enum logic [1:0] {
        S_WELCOME = 2'd0,
        S_PLAY    = 2'd1,
        S_OVER    = 2'd2
    } state_t;

    localparam logic [9:0] ROW_LIMIT = 10'(LOWER_BOUND);
    localparam logic [7:0] SCORE_TOP = 8'(SCORE_MAX);

    state_t cur_state, nxt_state;

    logic [NSLOTS-1:0] live;
    logic [7:0]        slot_ascii [NSLOTS];
    logic [9:0]        slot_col   [NSLOTS];
    logic [9:0]        slot_row   [NSLOTS];
    logic [2:0]        slot_speed [NSLOTS];

    logic              match;
    logic [IW-1:0]     victim;
    logic [9:0]        victim_row;
    logic              any_free;
    logic [IW-1:0]     free_idx;
    logic [9:0]        adv_row [NSLOTS];
    logic [NSLOTS-1:0] movers;
    logic              reach_bottom;
    logic              in_play;

    assign in_play = (cur_state == S_PLAY);

    // Victim is the lowest-on-screen matching slot; strict compare keeps the lowest index on ties.
    always_comb begin
        match      = 1'b0;
        victim     = '0;
        victim_row = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (key_valid && live[i] && (slot_ascii[i] == key_ascii) &&
                (!match || (slot_row[i] > victim_row))) begin
                match      = 1'b1;
                victim     = IW'(i);
                victim_row = slot_row[i];
            end
        end
    end

    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (!live[i] && !any_free) begin
                any_free = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    always_comb begin
        reach_bottom = 1'b0;
        movers       = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            adv_row[i] = slot_row[i] + ((slot_speed[i] == 3'd0) ? 10'd1 : {7'd0, slot_speed[i]});
            movers[i]  = tick && live[i] && !(match && (victim == IW'(i)));
            if (movers[i] && (adv_row[i] >= ROW_LIMIT)) begin
                reach_bottom = 1'b1;
            end
        end
    end

    assign spawn_ready = in_play && any_free;

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_WELCOME: if (start)        nxt_state = S_PLAY;
            S_PLAY:    if (reach_bottom) nxt_state = S_OVER;
            S_OVER:    if (start)        nxt_state = S_WELCOME;
            default:                     nxt_state = S_WELCOME;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_WELCOME;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live  <= '0;
            score <= '0;
            hit   <= 1'b0;
            for (int i = 0; i < NSLOTS; i++) begin
                slot_ascii[i] <= '0;
                slot_col[i]   <= '0;
                slot_row[i]   <= '0;
                slot_speed[i] <= '0;
            end
        end else begin
            hit <= 1'b0;
            if ((cur_state == S_WELCOME) && start) begin
                live  <= '0;
                score <= '0;
                for (int i = 0; i < NSLOTS; i++) begin
                    slot_ascii[i] <= '0;
                    slot_col[i]   <= '0;
                    slot_row[i]   <= '0;
                    slot_speed[i] <= '0;
                end
            end else if (in_play) begin
                for (int i = 0; i < NSLOTS; i++) begin
                    if (movers[i]) begin
                        slot_row[i] <= adv_row[i];
                    end
                end
                if (match) begin
                    live[victim]       <= 1'b0;
                    slot_ascii[victim] <= '0;
                    slot_col[victim]   <= '0;
                    slot_row[victim]   <= '0;
                    slot_speed[victim] <= '0;
                    hit                <= 1'b1;
                    if (score < SCORE_TOP) begin
                        score <= score + 8'd1;
                    end
                end
                // free_idx comes from live at cycle start, so it never aliases the victim.
                if (spawn_valid && any_free) begin
                    live[free_idx]       <= 1'b1;
                    slot_ascii[free_idx] <= spawn_ascii;
                    slot_col[free_idx]   <= spawn_col;
                    slot_row[free_idx]   <= {1'b0, spawn_row};
                    slot_speed[free_idx] <= spawn_speed;
                end
            end
        end
    end

    assign rd_live  = live[rd_idx];
    assign rd_ascii = rd_live ? slot_ascii[rd_idx] : 8'd0;
    assign rd_col   = rd_live ? slot_col[rd_idx]   : 10'd0;
    assign rd_row   = rd_live ? slot_row[rd_idx]   : 10'd0;

    assign state    = cur_state;
    assign gameover = (cur_state == S_OVER);

endmodule

// File: tb/tb_typing_game_sched.sv
// tb/tb_typing_game_sched.sv - directed and randomized bench for typing_game_sched with a behavioural slot model
module tb_typing_game_sched;
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       spawn_valid = 1'b0;
    logic [7:0] spawn_ascii = 8'd0;
    logic [9:0] spawn_col = 10'd0;
    logic [8:0] spawn_row = 9'd0;
    logic [2:0] spawn_speed = 3'd0;
    logic       spawn_ready;
    logic       tick = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_ascii = 8'd0;
    logic [2:0] rd_idx = 3'd0;
    logic       rd_live;
    logic [7:0] rd_ascii;
    logic [9:0] rd_col;
    logic [9:0] rd_row;
    logic [1:0] state;
    logic [7:0] score;
    logic       gameover;
    logic       hit;

    int n_tests = 0;
    int n_fail  = 0;

    int m_state;
    int m_score;
    bit m_hit;
    bit m_live [N];
    int m_ascii [N];
    int m_col [N];
    int m_row [N];
    int m_speed [N];

    typing_game_sched #(.NSLOTS(N), .LOWER_BOUND(480), .SCORE_MAX(255)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .spawn_valid(spawn_valid), .spawn_ascii(spawn_ascii), .spawn_col(spawn_col),
        .spawn_row(spawn_row), .spawn_speed(spawn_speed), .spawn_ready(spawn_ready),
        .tick(tick), .key_valid(key_valid), .key_ascii(key_ascii),
        .rd_idx(rd_idx), .rd_live(rd_live), .rd_ascii(rd_ascii), .rd_col(rd_col), .rd_row(rd_row),
        .state(state), .score(score), .gameover(gameover), .hit(hit)
    );

    always #10 clk = ~clk;

    task automatic model_reset();
        m_state = 0;
        m_score = 0;
        m_hit   = 0;
        for (int i = 0; i < N; i++) m_live[i] = 0;
    endtask

    // Game rules applied to the sampled inputs of one clock edge.
    task automatic model_update();
        int victim;
        int free_slot;
        bit reach;
        victim = -1;
        free_slot = -1;
        reach = 0;
        m_hit = 0;
        case (m_state)
            0: if (start) begin
                m_state = 1;
                m_score = 0;
                for (int i = 0; i < N; i++) m_live[i] = 0;
            end
            1: begin
                for (int i = 0; i < N; i++) if (!m_live[i] && free_slot < 0) free_slot = i;
                if (key_valid)
                    for (int i = 0; i < N; i++)
                        if (m_live[i] && m_ascii[i] == int'(key_ascii) && (victim < 0 || m_row[i] > m_row[victim]))
                            victim = i;
                if (tick)
                    for (int i = 0; i < N; i++)
                        if (m_live[i] && i != victim) begin
                            m_row[i] += (m_speed[i] == 0) ? 1 : m_speed[i];
                            if (m_row[i] >= 480) reach = 1;
                        end
                if (victim >= 0) begin
                    m_live[victim] = 0;
                    m_hit = 1;
                    if (m_score < 255) m_score++;
                end
                if (spawn_valid && free_slot >= 0) begin
                    m_live[free_slot]  = 1;
                    m_ascii[free_slot] = int'(spawn_ascii);
                    m_col[free_slot]   = int'(spawn_col);
                    m_row[free_slot]   = int'(spawn_row);
                    m_speed[free_slot] = int'(spawn_speed);
                end
                if (reach) m_state = 2;
            end
            default: if (start) m_state = 0;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        start = 0;
        spawn_valid = 0;
        tick = 0;
        key_valid = 0;
    endtask

    task automatic do_spawn(input logic [7:0] a, input int c, input int r, input int s);
        spawn_valid = 1;
        spawn_ascii = a;
        spawn_col   = 10'(c);
        spawn_row   = 9'(r);
        spawn_speed = 3'(s);
        step();
    endtask

    task automatic restart();
        rst_n = 0;
        model_reset();
        #3;
        rst_n = 1;
        start = 1;
        step();
    endtask

    task automatic test_reset();
        #15;
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
        n_tests++; if (score !== 8'd0) begin n_fail++; $display("FAIL reset_score got %0d want 0", score); end
        n_tests++; if ({gameover, hit, spawn_ready} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {gameover, hit, spawn_ready}); end
        for (int i = 0; i < N; i++) begin
            rd_idx = 3'(i);
            #1;
            n_tests++; if ({rd_live, rd_ascii, rd_col, rd_row} !== 29'd0) begin n_fail++; $display("FAIL reset_slot%0d got %h want 0", i, {rd_live, rd_ascii, rd_col, rd_row}); end
        end
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_start();
        start = 1;
        step();
        n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL start_state got %0d want 1", state); end
        n_tests++; if (score !== 8'd0) begin n_fail++; $display("FAIL start_score got %0d want 0", score); end
        n_tests++; if (spawn_ready !== 1'b1) begin n_fail++; $display("FAIL start_ready got %b want 1", spawn_ready); end
        for (int i = 0; i < N; i++) begin
            rd_idx = 3'(i);
            #1;
            n_tests++; if (rd_live !== 1'b0) begin n_fail++; $display("FAIL start_live%0d got %b want 0", i, rd_live); end
        end
    endtask

    task automatic test_move();
        do_spawn(8'h41, 16, 0, 3);
        repeat (4) begin tick = 1; step(); end
        rd_idx = 3'd0;
        #1;
        n_tests++; if ({rd_live, rd_ascii, rd_col, rd_row} !== {1'b1, 8'h41, 10'd16, 10'd12}) begin n_fail++; $display("FAIL move_slot0 got %h want %h", {rd_live, rd_ascii, rd_col, rd_row}, {1'b1, 8'h41, 10'd16, 10'd12}); end
        do_spawn(8'h42, 40, 50, 0);
        tick = 1;
        step();
        rd_idx = 3'd1;
        #1;
        n_tests++; if (rd_row !== 10'd51) begin n_fail++; $display("FAIL move_speed0 got %0d want 51", rd_row); end
        rd_idx = 3'd0;
        #1;
        n_tests++; if (rd_row !== 10'd15) begin n_fail++; $display("FAIL move_slot0b got %0d want 15", rd_row); end
    endtask

    task automatic test_fill();
        restart();
        for (int i = 0; i < N; i++) do_spawn(8'(8'h61 + i), i * 20, i * 10, 1);
        n_tests++; if (spawn_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", spawn_ready); end
        do_spawn(8'h78, 5, 5, 1);
        for (int i = 0; i < N; i++) begin
            rd_idx = 3'(i);
            #1;
            n_tests++; if (rd_ascii !== 8'(8'h61 + i)) begin n_fail++; $display("FAIL full_slot%0d got %h want %h", i, rd_ascii, 8'(8'h61 + i)); end
        end
        key_valid = 1;
        key_ascii = 8'h66;
        step();
        rd_idx = 3'd5;
        #1;
        n_tests++; if ({hit, spawn_ready, rd_live} !== 3'b110) begin n_fail++; $display("FAIL free5 got %b want 110", {hit, spawn_ready, rd_live}); end
        do_spawn(8'h79, 7, 7, 1);
        rd_idx = 3'd5;
        #1;
        n_tests++; if ({rd_live, rd_ascii, spawn_ready} !== {1'b1, 8'h79, 1'b0}) begin n_fail++; $display("FAIL reuse5 got %h want %h", {rd_live, rd_ascii, spawn_ready}, {1'b1, 8'h79, 1'b0}); end
    endtask

    task automatic test_victim();
        restart();
        do_spawn(8'h71, 0, 0, 1);
        do_spawn(8'h42, 100, 100, 2);
        do_spawn(8'h72, 0, 0, 1);
        do_spawn(8'h42, 200, 200, 2);
        key_valid = 1;
        key_ascii = 8'h42;
        tick = 1;
        step();
        n_tests++; if ({hit, score} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL victim_hit got %h want %h", {hit, score}, {1'b1, 8'd1}); end
        rd_idx = 3'd3;
        #1;
        n_tests++; if (rd_live !== 1'b0) begin n_fail++; $display("FAIL victim_cleared got %b want 0", rd_live); end
        rd_idx = 3'd1;
        #1;
        n_tests++; if ({rd_live, rd_row} !== {1'b1, 10'd102}) begin n_fail++; $display("FAIL victim_other got %h want %h", {rd_live, rd_row}, {1'b1, 10'd102}); end
        rd_idx = 3'd0;
        #1;
        n_tests++; if (rd_row !== 10'd1) begin n_fail++; $display("FAIL victim_slot0 got %0d want 1", rd_row); end
        key_valid = 1;
        key_ascii = 8'h5a;
        step();
        n_tests++; if ({hit, score} !== {1'b0, 8'd1}) begin n_fail++; $display("FAIL nomatch got %h want %h", {hit, score}, {1'b0, 8'd1}); end
    endtask

    task automatic test_gameover();
        restart();
        do_spawn(8'h47, 0, 478, 2);
        tick = 1;
        step();
        n_tests++; if ({state, gameover} !== {2'd2, 1'b1}) begin n_fail++; $display("FAIL over got %b want 101", {state, gameover}); end
        tick = 1;
        step();
        rd_idx = 3'd0;
        #1;
        n_tests++; if ({rd_live, rd_row} !== {1'b1, 10'd480}) begin n_fail++; $display("FAIL over_hold got %h want %h", {rd_live, rd_row}, {1'b1, 10'd480}); end
        start = 1;
        step();
        n_tests++; if ({state, gameover} !== {2'd0, 1'b0}) begin n_fail++; $display("FAIL over_exit got %b want 000", {state, gameover}); end
        restart();
        do_spawn(8'h4b, 0, 478, 2);
        key_valid = 1;
        key_ascii = 8'h4b;
        tick = 1;
        step();
        n_tests++; if ({state, hit} !== {2'd1, 1'b1}) begin n_fail++; $display("FAIL saved got %b want 011", {state, hit}); end
        do_spawn(8'h4c, 0, 500, 1);
        n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL low_spawn got %0d want 1", state); end
        tick = 1;
        step();
        n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL low_tick got %0d want 2", state); end
    endtask

    task automatic test_score_sat();
        restart();
        repeat (255) begin
            do_spawn(8'h53, 0, 0, 1);
            key_valid = 1;
            key_ascii = 8'h53;
            step();
        end
        n_tests++; if (score !== 8'd255) begin n_fail++; $display("FAIL score_255 got %0d want 255", score); end
        repeat (2) begin
            do_spawn(8'h53, 0, 0, 1);
            key_valid = 1;
            key_ascii = 8'h53;
            step();
        end
        n_tests++; if ({hit, score} !== {1'b1, 8'd255}) begin n_fail++; $display("FAIL score_sat got %h want %h", {hit, score}, {1'b1, 8'd255}); end
    endtask

    task automatic test_reset_mid();
        restart();
        do_spawn(8'h4d, 0, 10, 1);
        do_spawn(8'h4e, 0, 20, 1);
        key_valid = 1;
        key_ascii = 8'h4d;
        step();
        #3;
        rst_n = 0;
        model_reset();
        #1;
        rd_idx = 3'd1;
        #1;
        n_tests++; if ({state, score, hit, gameover, spawn_ready} !== 13'd0) begin n_fail++; $display("FAIL midreset got %h want 0", {state, score, hit, gameover, spawn_ready}); end
        n_tests++; if ({rd_live, rd_ascii, rd_col, rd_row} !== 29'd0) begin n_fail++; $display("FAIL midreset_rd got %h want 0", {rd_live, rd_ascii, rd_col, rd_row}); end
        rst_n = 1;
    endtask

    task automatic test_random();
        logic [28:0] got;
        logic [28:0] exp;
        bit any_free;
        restart();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            start       = ($urandom_range(0, 99) < 5);
            spawn_valid = $urandom_range(0, 1) == 1;
            spawn_ascii = 8'($urandom_range(65, 68));
            spawn_col   = 10'($urandom_range(0, 639));
            spawn_row   = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(470, 511)) : 9'($urandom_range(0, 200));
            spawn_speed = 3'($urandom_range(0, 7));
            tick        = ($urandom_range(0, 9) < 4);
            key_valid   = $urandom_range(0, 1) == 1;
            key_ascii   = 8'($urandom_range(65, 69));
            step();
            any_free = 0;
            for (int i = 0; i < N; i++) if (!m_live[i]) any_free = 1;
            n_tests++; if ({state, score, hit, gameover} !== {2'(m_state), 8'(m_score), m_hit, m_state == 2}) begin n_fail++; $display("FAIL rand_status cyc %0d got %h want %h", cyc, {state, score, hit, gameover}, {2'(m_state), 8'(m_score), m_hit, m_state == 2}); end
            n_tests++; if (spawn_ready !== (m_state == 1 && any_free)) begin n_fail++; $display("FAIL rand_ready cyc %0d got %b want %b", cyc, spawn_ready, (m_state == 1 && any_free)); end
            for (int i = 0; i < N; i++) begin
                rd_idx = 3'(i);
                #1;
                got = {rd_live, rd_ascii, rd_col, rd_row};
                exp = m_live[i] ? {1'b1, 8'(m_ascii[i]), 10'(m_col[i]), 10'(m_row[i])} : 29'd0;
                n_tests++; if (got !== exp) begin n_fail++; $display("FAIL rand_slot%0d cyc %0d got %h want %h", i, cyc, got, exp); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_move();
        test_fill();
        test_victim();
        test_gameover();
        test_score_sat();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
